alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters, e.g. port 0 = main datapath, port 1 = address/branch unit.
//  Each request is a valid/ready transaction carrying an op, src1 and src2.
//  The block arbitrates round-robin, drives the ALU from registered operands and captures its outputs.
//  It returns one tagged response per request. One transaction is in flight at a time.
// PARAMETERS
//  DATA_W  32  operand/result width
//  OP_W    4   ALU operation code width; passed through unmodified
// PORTS
//  clk_i            in   1          clock; all state updates on rising edge
//  rst_i            in   1          synchronous, active-high reset
//  req_valid_i      in   2          bit k: requester k presents a request
//  req_ready_o      out  2          bit k: request k is accepted this cycle if valid
//  req_op_i         in   2*OP_W     packed op; port k at [k*OP_W +: OP_W]
//  req_src1_i       in   2*DATA_W   packed src1; port k at [k*DATA_W +: DATA_W]
//  req_src2_i       in   2*DATA_W   packed src2; same packing as req_src1_i
//  resp_valid_o     out  1          response available
//  resp_id_o        out  1          requester that owns the response
//  resp_ready_i     in   1          response consumed this cycle if valid
//  resp_result_o    out  DATA_W     captured ALU result
//  resp_zero_o      out  1          captured ALU zero flag
//  resp_overflow_o  out  1          captured ALU overflow flag
//  alu_op_o         out  OP_W       to shared ALU: operation
//  alu_src1_o       out  DATA_W     to shared ALU: operand 1
//  alu_src2_o       out  DATA_W     to shared ALU: operand 2
//  alu_result_i     in   DATA_W     from shared ALU: result (combinational)
//  alu_zero_i       in   1          from shared ALU: zero flag
//  alu_overflow_i   in   1          from shared ALU: overflow flag
//  busy_o           out  1          high in EXEC or RESP
// BEHAVIOUR
//  Reset:
//   - state=IDLE, prio=0 (port 0 preferred).
//   - Op/src/id/result/flag registers cleared to 0.
//   - Every output is 0.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE:
//    - grant = single valid port; if both valid, grant = prio.
//    - req_ready_o = onehot(grant), asserted only when that port is valid; 0 otherwise.
//    - On valid&ready: latch op/src1/src2, id=grant; go to EXEC.
//   EXEC (1 cycle):
//    - ALU inputs are already stable from the latch.
//    - Capture alu_result_i/zero/overflow into the response regs; go to RESP.
//   RESP:
//    - resp_valid_o=1, resp_id_o=id; all response outputs held stable.
//    - On resp_ready_i: prio = ~id, go to IDLE.
//  Timing:
//   - Accept at edge N; resp_valid_o high from cycle N+2.
//   - Best-case throughput: 1 op per 3 cycles.
//  Outputs per state:
//   - req_ready_o=0 in EXEC and RESP, so no new request is accepted while one is in flight.
//   - alu_*_o always reflect the latched registers, stable from EXEC through RESP.
//  Fairness:
//   - prio flips only on response completion, so under continuous contention ports alternate 0,1,0,1.
//   - A lone requester is served back-to-back regardless of prio.
//  Requester rules:
//   - A requester may deassert valid before acceptance; no transaction results.
//   - Requester inputs are ignored once the request is latched.
//  resp_ready_i outside RESP: ignored.
//  Reset mid-operation (EXEC or RESP):
//   - The in-flight op is dropped and no response is issued.
//   - Next cycle is IDLE with prio=0.
//  Ops/flags: no decode or width change; ALU outputs are passed through bit-exact.
// TESTING
//  1. Reset, then port0 op=2 src=5,7 -> ready0 at accept; resp cycle+2: id=0, result=12, zero=0.
//  2. Both valid in same cycle after reset -> port0 served first, then port1, then port0 (alternation over 4 ops).
//  3. Port1 op=6 src1=src2=0x1234; resp_ready low 5 cycles -> resp held stable, result=0, zero=1, no new accept.
//  4. Port0 op=2 src1=0x7FFFFFFF src2=1 -> result=0x80000000, overflow taken from ALU; busy_o high for exactly EXEC+RESP.
//  5. rst_i pulsed during EXEC -> no resp_valid_o; next request granted normally with prio=0.
//  6. valid0 pulsed for 1 cycle while busy -> never accepted; valid1 held is served after the current response.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for one shared combinational ALU.
// One transaction in flight: accept -> drive ALU from latched operands -> hold tagged response.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*OP_W-1:0]   req_op_i,
    input  logic [2*DATA_W-1:0] req_src1_i,
    input  logic [2*DATA_W-1:0] req_src2_i,
    output logic                resp_valid_o,
    output logic                resp_id_o,
    input  logic                resp_ready_i,
    output logic [DATA_W-1:0]   resp_result_o,
    output logic                resp_zero_o,
    output logic                resp_overflow_o,
    output logic [OP_W-1:0]     alu_op_o,
    output logic [DATA_W-1:0]   alu_src1_o,
    output logic [DATA_W-1:0]   alu_src2_o,
    input  logic [DATA_W-1:0]   alu_result_i,
    input  logic                alu_zero_i,
    input  logic                alu_overflow_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                id_q, id_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   src1_q, src1_d;
    logic [DATA_W-1:0]   src2_q, src2_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                grant;

    // Contention resolves to prio; a lone requester wins regardless of prio.
    assign grant = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        req_ready_o = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o[grant] = 1'b1;
                    id_d    = grant;
                    op_d    = grant ? req_op_i[2*OP_W-1:OP_W]       : req_op_i[OP_W-1:0];
                    src1_d  = grant ? req_src1_i[2*DATA_W-1:DATA_W] : req_src1_i[DATA_W-1:0];
                    src2_d  = grant ? req_src2_i[2*DATA_W-1:DATA_W] : req_src2_i[DATA_W-1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result_i;
                zero_d   = alu_zero_i;
                ovf_d    = alu_overflow_i;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    prio_d  = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign resp_valid_o    = (state_q == RESP);
    assign resp_id_o       = id_q;
    assign resp_result_o   = result_q;
    assign resp_zero_o     = zero_q;
    assign resp_overflow_o = ovf_q;
    assign alu_op_o        = op_q;
    assign alu_src1_o      = src1_q;
    assign alu_src2_o      = src2_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter with a bench-side ALU stub
// and a transaction-level model of grant order, latency and response content.
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0] req_valid, req_ready;
    logic [2*OW-1:0] req_op;
    logic [2*DW-1:0] req_s1, req_s2;
    logic resp_valid, resp_id, resp_ready, resp_zero, resp_ovf;
    logic [DW-1:0] resp_result;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_s1, alu_s2, alu_res;
    logic alu_zero, alu_ovf, busy;

    logic vld[2];
    logic [OW-1:0] opv[2];
    logic [DW-1:0] av[2], bv[2];

    always_comb begin
        req_valid = {vld[1], vld[0]};
        req_op    = {opv[1], opv[0]};
        req_s1    = {av[1], av[0]};
        req_s2    = {bv[1], bv[0]};
    end

    // Shared ALU stub: add=2, sub=6, and=0, or=1, others xor.
    function automatic logic [DW+1:0] alu_stub(input logic [OW-1:0] op, input logic [DW-1:0] a, b);
        logic [DW-1:0] r;
        logic v;
        v = 1'b0;
        case (op)
            4'd2: begin r = a + b; v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            4'd6: begin r = a - b; v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            4'd0: r = a & b;
            4'd1: r = a | b;
            default: r = a ^ b;
        endcase
        return {v, (r == '0), r};
    endfunction

    assign {alu_ovf, alu_zero, alu_res} = alu_stub(alu_op, alu_s1, alu_s2);

    alu_share_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_src1_i(req_s1), .req_src2_i(req_s2),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_ready_i(resp_ready),
        .resp_result_o(resp_result), .resp_zero_o(resp_zero), .resp_overflow_o(resp_ovf),
        .alu_op_o(alu_op), .alu_src1_o(alu_s1), .alu_src2_o(alu_s2),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero), .alu_overflow_i(alu_ovf),
        .busy_o(busy)
    );

    typedef struct packed {
        logic          id;
        logic [DW-1:0] res;
        logic          z;
        logic          v;
    } exp_t;

    // Reference: full-precision signed arithmetic, overflow = out of DW-bit signed range.
    function automatic exp_t model(input logic id, input logic [OW-1:0] op, input logic [DW-1:0] a, b);
        exp_t e;
        longint x, y, s;
        x = longint'($signed(a));
        y = longint'($signed(b));
        e.id = id;
        e.v  = 1'b0;
        if (op == 4'd2 || op == 4'd6) begin
            s = (op == 4'd2) ? x + y : x - y;
            e.res = s[DW-1:0];
            e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 4'd0) e.res = a & b;
        else if (op == 4'd1) e.res = a | b;
        else e.res = a ^ b;
        e.z = (e.res == 0);
        return e;
    endfunction

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    exp_t q[$];
    logic served[$];
    bit mbusy = 0, mprio = 0;
    int acc_cyc = 0;
    int rr_mode = 0;

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            mbusy = 0;
            mprio = 0;
            continue;
        end
        chk("busy", busy, mbusy);
        chk("ready_without_valid", req_ready & ~req_valid, 0);
        if (mbusy) chk("ready_while_busy", req_ready, 0);
        if (!mbusy || cyc < acc_cyc + 2) chk("resp_valid_early", resp_valid, 0);
        else if (cyc == acc_cyc + 2) chk("resp_latency", resp_valid, 1);
        if (mbusy && resp_valid && q.size() > 0) begin
            chk("resp_id", resp_id, q[0].id);
            chk("resp_result", resp_result, q[0].res);
            chk("resp_zero", resp_zero, q[0].z);
            chk("resp_overflow", resp_ovf, q[0].v);
            if (resp_ready) begin
                served.push_back(q[0].id);
                mprio = ~q[0].id;
                void'(q.pop_front());
                mbusy = 0;
            end
        end else if (!mbusy && (req_valid & req_ready) != 2'b00) begin
            logic g;
            if (req_valid == 2'b01) g = 1'b0;
            else if (req_valid == 2'b10) g = 1'b1;
            else g = mprio;
            chk("grant", req_ready, g ? 2'b10 : 2'b01);
            q.push_back(model(g, opv[g], av[g], bv[g]));
            acc_cyc = cyc;
            mbusy = 1;
        end
    end

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom % 2) : 1'b0;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after acceptance.
    task automatic send(input int p, input logic [OW-1:0] o, input logic [DW-1:0] a, b);
        bit ok;
        ok = 0;
        vld[p] = 1'b1; opv[p] = o; av[p] = a; bv[p] = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        vld[p] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!mbusy && q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_resp"}, {resp_valid, resp_id, resp_zero, resp_ovf}, 0);
        chk({tag, "_result"}, resp_result, 0);
        chk({tag, "_alu"}, {alu_op, alu_s1, alu_s2}, 0);
        chk({tag, "_busy"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin vld[p] = 0; opv[p] = 0; av[p] = 0; bv[p] = 0; end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // 1: simple add on port 0
        served.delete();
        send(0, 4'd2, 32'd5, 32'd7);
        wait_idle();
        chk("t1_served", served.size(), 1);

        // 2: contention after reset alternates starting at port 0
        do_reset();
        served.delete();
        fork
            begin send(0, 4'd2, 32'd1, 32'd2); send(0, 4'd0, 32'hF0F0, 32'hFF00); end
            begin send(1, 4'd6, 32'd9, 32'd3); send(1, 4'd1, 32'h1, 32'h10); end
        join
        wait_idle();
        chk("t2_count", served.size(), 4);
        if (served.size() == 4)
            chk("t2_order", {served[0], served[1], served[2], served[3]}, 4'b0101);

        // 3: backpressure holds the response stable
        rr_mode = 2;
        send(1, 4'd6, 32'h1234, 32'h1234);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        repeat (5) @(negedge clk);
        chk("t3_held_valid", resp_valid, 1);
        chk("t3_zero", resp_zero, 1);
        rr_mode = 0;
        wait_idle();

        // 4: signed overflow passes through
        send(0, 4'd2, 32'h7FFF_FFFF, 32'd1);
        wait_idle();

        // 5: reset during EXEC drops the op and restores port-0 priority
        send(0, 4'd1, 32'hA5, 32'h5A);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midreset");
        served.delete();
        fork
            send(0, 4'd3, 32'h1111, 32'h2222);
            send(1, 4'd2, 32'd100, 32'd200);
        join
        wait_idle();
        chk("t5_count", served.size(), 2);
        if (served.size() == 2) chk("t5_first", served[0], 0);

        // 6: one-cycle valid0 pulse while busy is never accepted
        rr_mode = 2;
        send(0, 4'd2, 32'd40, 32'd2);
        served.delete();
        fork
            send(1, 4'd6, 32'd50, 32'd8);
            begin
                vld[0] = 1'b1; opv[0] = 4'd1; av[0] = 32'hDEAD; bv[0] = 32'hBEEF;
                @(posedge clk);
                #1;
                vld[0] = 1'b0;
                repeat (3) @(negedge clk);
                rr_mode = 0;
            end
        join
        wait_idle();
        chk("t6_count", served.size(), 2);
        if (served.size() == 2) chk("t6_order", {served[0], served[1]}, 2'b01);

        // Random traffic with random backpressure
        rr_mode = 1;
        for (int it = 0; it < 40; it++) begin
            fork
                begin
                    if ($urandom % 4 != 0) begin
                        repeat ($urandom % 3) begin @(posedge clk); #1; end
                        send(0, 4'($urandom % 8), $urandom, ($urandom % 4 == 0) ? 32'd0 : $urandom);
                    end
                end
                begin
                    if ($urandom % 4 != 0) begin
                        repeat ($urandom % 3) begin @(posedge clk); #1; end
                        send(1, 4'($urandom % 8), $urandom, $urandom);
                    end
                end
            join
        end
        rr_mode = 0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
